// File: rtl/system_qsys_nios2_jtag_cmd_sysclk_queue_if.sv
`default_nettype none
// ============================================================================
//  Module  : system_qsys_nios2_jtag_cmd_sysclk_queue_if
//  Brief   : Command-queue consumer bundle for the Nios II JTAG sysclk queue.
//  Revision: 1.0  initial release
// ============================================================================
interface system_qsys_nios2_jtag_cmd_sysclk_queue_if #(
    parameter int SR_W   = 38,
    parameter int IR_W   = 2,
    parameter int NUM_CH = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [IR_W-1:0]   cmd_ch;
    logic              cmd_take;
    logic [SR_W-1:0]   jdo;
    logic [NUM_CH-1:0] take_action;
    logic [NUM_CH-1:0] take_no_action;

    // master: the queue producing commands; slave: the consumer popping them
    modport master (
        output cmd_valid, cmd_ch, cmd_take, jdo, take_action, take_no_action,
        input  cmd_ready
    );
    modport slave (
        input  cmd_valid, cmd_ch, cmd_take, jdo, take_action, take_no_action,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/system_qsys_nios2_jtag_cmd_sysclk_queue.sv
`default_nettype none
// ============================================================================
//  Module  : system_qsys_nios2_jtag_cmd_sysclk_queue
//  Brief   : Synchronises JTAG update strobes into clk, decodes update-DR
//            into channel commands and queues them with drop/error accounting.
//  Revision: 1.0  initial release
// ============================================================================
module system_qsys_nios2_jtag_cmd_sysclk_queue #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int NUM_CH      = 4,
    parameter int ACT_BIT     = 37,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic                            clk,
    input  wire logic                            reset,
    input  wire logic                            vs_uir,
    input  wire logic                            vs_udr,
    input  wire logic [IR_W-1:0]                 ir_in,
    input  wire logic [SR_W-1:0]                 sr,
    input  wire logic [NUM_CH-1:0]               ch_enable,
    input  wire logic                            clear_status,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
    output logic                                 overflow,
    output logic [7:0]                           drop_cnt,
    output logic [7:0]                           err_cnt,
    system_qsys_nios2_jtag_cmd_sysclk_queue_if.master cmd_if
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam logic [c_PTR_W-1:0] c_FULL = c_PTR_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Strobe synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_uir_sync, r_udr_sync;
    logic                   r_uir_last, r_udr_last;
    logic                   r_uir_arm,  r_udr_arm;
    logic                   r_uir_p,    r_udr_p;
    logic                   r_live;

    // An edge only counts once the synchronised level has been seen low after
    // reset, so a strobe already high at release cannot fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_uir_sync <= '0;
            r_udr_sync <= '0;
            r_uir_last <= 1'b0;
            r_udr_last <= 1'b0;
            r_uir_arm  <= 1'b0;
            r_udr_arm  <= 1'b0;
            r_uir_p    <= 1'b0;
            r_udr_p    <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_last <= r_uir_sync[SYNC_STAGES-1];
            r_udr_last <= r_udr_sync[SYNC_STAGES-1];
            r_live     <= 1'b1;
            r_uir_arm  <= r_uir_arm | (r_live & ~r_uir_sync[0]);
            r_udr_arm  <= r_udr_arm | (r_live & ~r_udr_sync[0]);
            r_uir_p    <= r_uir_sync[SYNC_STAGES-1] & ~r_uir_last & r_uir_arm;
            r_udr_p    <= r_udr_sync[SYNC_STAGES-1] & ~r_udr_last & r_udr_arm;
        end
    end

    // ------------------------------------------------------------------
    // Command decode and queue control
    // ------------------------------------------------------------------
    logic [IR_W-1:0]    r_ir;
    logic [c_PTR_W-1:0] r_wptr, r_rptr;
    logic [SR_W-1:0]    r_mem_data [FIFO_DEPTH];
    logic [IR_W-1:0]    r_mem_ch   [FIFO_DEPTH];
    logic               r_mem_take [FIFO_DEPTH];

    logic [NUM_CH-1:0]  w_cmd_sel;
    logic               w_cmd_ok;
    logic [c_PTR_W-1:0] w_level;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_err;
    logic [IR_W-1:0]    w_head_ch;
    logic               w_head_take;
    logic [NUM_CH-1:0]  w_head_sel;

    // Channels at or beyond NUM_CH shift out of the mask, so one test covers both
    assign w_cmd_sel   = NUM_CH'(1) << r_ir;
    assign w_cmd_ok    = |(ch_enable & w_cmd_sel);
    assign w_level     = r_wptr - r_rptr;
    assign w_valid     = (w_level != '0);
    assign w_pop       = w_valid & cmd_if.cmd_ready;
    assign w_push      = r_udr_p & w_cmd_ok & ((w_level != c_FULL) | w_pop);
    assign w_drop      = r_udr_p & w_cmd_ok & ~w_push;
    assign w_err       = r_udr_p & ~w_cmd_ok;
    assign w_head_ch   = r_mem_ch[r_rptr[c_ADDR_W-1:0]];
    assign w_head_take = r_mem_take[r_rptr[c_ADDR_W-1:0]];
    assign w_head_sel  = NUM_CH'(1) << w_head_ch;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr[c_ADDR_W-1:0]] <= sr;
            r_mem_ch[r_wptr[c_ADDR_W-1:0]]   <= r_ir;
            r_mem_take[r_wptr[c_ADDR_W-1:0]] <= sr[ACT_BIT];
        end
    end

    logic [SR_W-1:0]   r_jdo;
    logic [NUM_CH-1:0] r_take_action, r_take_no_action;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt, r_err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir             <= '0;
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_jdo            <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_overflow       <= 1'b0;
            r_drop_cnt       <= '0;
            r_err_cnt        <= '0;
        end else begin
            // r_udr_p reads r_ir before this update lands
            if (r_uir_p)
                r_ir <= ir_in;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_jdo  <= r_mem_data[r_rptr[c_ADDR_W-1:0]];
                if (w_head_take)
                    r_take_action    <= w_head_sel;
                else
                    r_take_no_action <= w_head_sel;
            end

            // A drop or error coinciding with clear restarts its count at 1
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clear_status)
                r_overflow <= 1'b0;

            if (w_drop)
                r_drop_cnt <= clear_status ? 8'd1 :
                              (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;
            else if (clear_status)
                r_drop_cnt <= '0;

            if (w_err)
                r_err_cnt <= clear_status ? 8'd1 :
                             (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
            else if (clear_status)
                r_err_cnt <= '0;
        end
    end

    assign fifo_level             = w_level;
    assign overflow               = r_overflow;
    assign drop_cnt               = r_drop_cnt;
    assign err_cnt                = r_err_cnt;
    assign cmd_if.cmd_valid       = w_valid;
    assign cmd_if.cmd_ch          = w_valid ? w_head_ch : '0;
    assign cmd_if.cmd_take        = w_valid & w_head_take;
    assign cmd_if.jdo             = r_jdo;
    assign cmd_if.take_action     = r_take_action;
    assign cmd_if.take_no_action  = r_take_no_action;

endmodule
`default_nettype wire

// File: tb/tb_system_qsys_nios2_jtag_cmd_sysclk_queue.sv
`default_nettype none
// ============================================================================
//  Module  : tb_system_qsys_nios2_jtag_cmd_sysclk_queue
//  Brief   : Directed self-checking bench for the JTAG sysclk command queue.
//  Revision: 1.0  initial release
// ============================================================================
module tb_system_qsys_nios2_jtag_cmd_sysclk_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_uir, vs_udr;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic [3:0]  ch_enable;
    logic        clear_status;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_cnt, err_cnt;

    system_qsys_nios2_jtag_cmd_sysclk_queue_if #(.SR_W(38), .IR_W(2), .NUM_CH(4)) q_if ();

    system_qsys_nios2_jtag_cmd_sysclk_queue dut (
        .clk          (clk),
        .reset        (reset),
        .vs_uir       (vs_uir),
        .vs_udr       (vs_udr),
        .ir_in        (ir_in),
        .sr           (sr),
        .ch_enable    (ch_enable),
        .clear_status (clear_status),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .err_cnt      (err_cnt),
        .cmd_if       (q_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: cumulative counts, last pulse values, jdo at each pulse
    int          act_cnt = 0, nact_cnt = 0;
    logic [3:0]  last_act = '0, last_nact = '0;
    logic [37:0] got_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (q_if.take_action != 4'b0) begin
                act_cnt++;
                last_act = q_if.take_action;
                got_q.push_back(q_if.jdo);
            end
            if (q_if.take_no_action != 4'b0) begin
                nact_cnt++;
                last_nact = q_if.take_no_action;
                got_q.push_back(q_if.jdo);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_uir(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        step(3);
        vs_uir = 1'b0;
        step(3);
    endtask

    task automatic strobe_udr(input logic [37:0] val);
        sr     = val;
        vs_udr = 1'b1;
        step(3);
        vs_udr = 1'b0;
        step(3);
    endtask

    int a0, n0, q0;

    initial begin
        reset = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
        ch_enable = 4'hF; clear_status = 1'b0; q_if.cmd_ready = 1'b1;
        step(2);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_valid", 64'(q_if.cmd_valid), 64'd0);
        chk("rst_jdo", 64'(q_if.jdo), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        step(2);

        // T1: ch2 action
        strobe_uir(2'd2);
        a0 = act_cnt; q0 = got_q.size();
        strobe_udr({1'b1, 37'h2A});
        chk("t1_act_cnt", 64'(act_cnt - a0), 64'd1);
        chk("t1_act_val", 64'(last_act), 64'b0100);
        chk("t1_jdo", 64'(q_if.jdo), 64'h20_0000_002A);
        chk("t1_err", 64'(err_cnt), 64'd0);

        // T2: long-held udr gives one pulse, 4-clk latency
        strobe_uir(2'd1);
        a0 = act_cnt; n0 = nact_cnt;
        sr = {1'b0, 37'h55};
        vs_udr = 1'b1;
        step(3);
        chk("t2_lat3", 64'(q_if.cmd_valid), 64'd0);
        step(1);
        chk("t2_lat4", 64'(q_if.cmd_valid), 64'd1);
        chk("t2_ch", 64'(q_if.cmd_ch), 64'd1);
        step(20);
        vs_udr = 1'b0;
        step(3);
        chk("t2_nact_cnt", 64'(nact_cnt - n0), 64'd1);
        chk("t2_nact_val", 64'(last_nact), 64'b0010);
        chk("t2_act_cnt", 64'(act_cnt - a0), 64'd0);

        // T3: overflow then ordered drain
        q_if.cmd_ready = 1'b0;
        strobe_uir(2'd0);
        for (int i = 1; i <= 5; i++) strobe_udr({1'b1, 37'(i)});
        chk("t3_level", 64'(fifo_level), 64'd4);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drop", 64'(drop_cnt), 64'd1);
        chk("t3_take", 64'(q_if.cmd_take), 64'd1);
        a0 = act_cnt; q0 = got_q.size();
        q_if.cmd_ready = 1'b1;
        step(8);
        chk("t3_act_cnt", 64'(act_cnt - a0), 64'd4);
        chk("t3_act_val", 64'(last_act), 64'b0001);
        if (got_q.size() >= q0 + 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", 64'(got_q[q0+i]), 64'({1'b1, 37'(i + 1)}));
        end else begin
            chk("t3_qsize", 64'(got_q.size() - q0), 64'd4);
        end
        chk("t3_drained", 64'(fifo_level), 64'd0);

        // T4: disabled channel counted as error; clear_status
        q_if.cmd_ready = 1'b0;
        ch_enable = 4'b1110;
        a0 = act_cnt;
        strobe_udr({1'b1, 37'h77});
        chk("t4_level", 64'(fifo_level), 64'd0);
        chk("t4_err", 64'(err_cnt), 64'd1);
        chk("t4_act_cnt", 64'(act_cnt - a0), 64'd0);
        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
        chk("t4_err_clr", 64'(err_cnt), 64'd0);
        chk("t4_ovf_clr", 64'(overflow), 64'd0);
        chk("t4_drop_clr", 64'(drop_cnt), 64'd0);
        ch_enable = 4'hF;

        // T5: full queue, pop and push in the same cycle
        for (int i = 0; i < 4; i++) strobe_udr({1'b0, 37'(8'h10 + i)});
        chk("t5_full", 64'(fifo_level), 64'd4);
        n0 = nact_cnt; q0 = got_q.size();
        sr = {1'b0, 37'h14};
        vs_udr = 1'b1;
        step(3);
        q_if.cmd_ready = 1'b1;
        step(1);
        q_if.cmd_ready = 1'b0;
        chk("t5_level", 64'(fifo_level), 64'd4);
        chk("t5_ovf", 64'(overflow), 64'd0);
        chk("t5_drop", 64'(drop_cnt), 64'd0);
        vs_udr = 1'b0;
        step(3);
        q_if.cmd_ready = 1'b1;
        step(8);
        chk("t5_nact_cnt", 64'(nact_cnt - n0), 64'd5);
        if (got_q.size() >= q0 + 5) begin
            chk("t5_first", 64'(got_q[q0]), 64'h10);
            chk("t5_last", 64'(got_q[q0+4]), 64'h14);
        end else begin
            chk("t5_qsize", 64'(got_q.size() - q0), 64'd5);
        end

        // T6: reset mid-operation with vs_udr high
        q_if.cmd_ready = 1'b0;
        for (int i = 1; i <= 3; i++) strobe_udr({1'b1, 37'(8'h30 + i)});
        chk("t6_level3", 64'(fifo_level), 64'd3);
        vs_udr = 1'b1;
        step(1);
        reset = 1'b1;
        #1;
        chk("t6_rst_level", 64'(fifo_level), 64'd0);
        chk("t6_rst_valid", 64'(q_if.cmd_valid), 64'd0);
        chk("t6_rst_jdo", 64'(q_if.jdo), 64'd0);
        step(2);
        reset = 1'b0;
        q_if.cmd_ready = 1'b1;
        a0 = act_cnt; n0 = nact_cnt;
        step(10);
        chk("t6_no_pulse", 64'((act_cnt - a0) + (nact_cnt - n0)), 64'd0);
        chk("t6_level0", 64'(fifo_level), 64'd0);
        vs_udr = 1'b0;
        step(3);
        strobe_udr({1'b1, 37'h3C});
        chk("t6_re_act", 64'(act_cnt - a0), 64'd1);
        chk("t6_re_val", 64'(last_act), 64'b0001);
        chk("t6_re_jdo", 64'(q_if.jdo), 64'({1'b1, 37'h3C}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
